// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Fetches 16-bit instruction words over a valid/ready handshake and steps
// each one through a three-cycle IDLE -> EXEC -> WB sequence. An external
// ALU does the arithmetic: during EXEC the sequencer drives the operation
// and operands, and it captures the ALU result and flags at the end of EXEC.
// During WB it writes the result back to the register file and updates the
// flags. Opcode 15 (HALT) parks the FSM until reset.
//
// Instruction word:
//   [15:12] opcode   [11:10] dst   [9] imm   [8] reserved
//   [7:0]   imm8 when imm=1, otherwise [1:0] = src
//
// Configuration macro:
//   ALU_SEQUENCER_IMM_EN  defined   : bit [9] selects imm8 as operand B
//                         undefined : bit [9] is ignored, operand B = R[src]
//
// Ports:
//   clk          sole clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   instr_valid  instruction word offered
//   instr_data   16-bit instruction word
//   instr_ready  sequencer accepts a word (IDLE with rst_n high only)
//   alu_mode     ALU operation select (non-zero only during EXEC)
//   alu_a        ALU operand A = R[dst] (non-zero only during EXEC)
//   alu_b        ALU operand B = imm8 or R[src] (non-zero only during EXEC)
//   alu_result   ALU result, sampled at the end of EXEC
//   alu_flags    ALU flags: [7] zero, [6] sign, [5] carry, [4] overflow
//   flags        architectural flags register, [3:0] always zero
//   retire       one-cycle pulse in WB of every completed instruction
//   halted       HALT has executed
//   dbg_sel      debug register select
//   dbg_data     combinational read of R[dbg_sel]
//   dbg_state    current FSM state (IDLE=0, EXEC=1, WB=2, HALT=3)
//
// Handshake: a word transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready does not depend on instr_valid,
// and the offered word is ignored in every other cycle.
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [15:0]          instr_data,
  output logic                 instr_ready,
  output logic [3:0]           alu_mode,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic [7:0]           alu_flags,
  output logic [7:0]           flags,
  output logic                 retire,
  output logic                 halted,
  input  logic [1:0]           dbg_sel,
  output logic [WORD_SIZE-1:0] dbg_data,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_TSTZ = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [15:0]          ir_q;
  logic [WORD_SIZE-1:0] regs_q [4];
  logic [3:0]           flags_q;      // architectural flags[7:4]
  logic [WORD_SIZE-1:0] wb_data_q;    // value captured at the end of EXEC
  logic [3:0]           alu_flags_q;  // ALU flags[7:4] captured at the end of EXEC

  logic [3:0]           opcode;
  logic [1:0]           dst;
  logic [1:0]           src;
  logic [WORD_SIZE-1:0] operand_b;
  logic                 in_exec;
  logic                 write_en;
  logic                 flag_all_en;
  logic                 flag_zero_en;

  assign opcode  = ir_q[15:12];
  assign dst     = ir_q[11:10];
  assign src     = ir_q[1:0];
  assign in_exec = (state_q == ST_EXEC);

`ifdef ALU_SEQUENCER_IMM_EN
  assign operand_b = ir_q[9] ? WORD_SIZE'(ir_q[7:0]) : regs_q[src];

  // Bit 8 is reserved; alu_flags[3:0] carry no architectural meaning.
  logic unused_bits;
  assign unused_bits = ^{ir_q[8], alu_flags[3:0]};
`else
  assign operand_b = regs_q[src];

  // Immediate field and reserved bit are not decoded in this build.
  logic unused_bits;
  assign unused_bits = ^{ir_q[9:2], alu_flags[3:0]};
`endif

  // Register writeback: MOV and opcodes 4..14.
  assign write_en     = (opcode == OP_MOV) || ((opcode >= 4'd4) && (opcode <= 4'd14));
  // Full flag load: opcodes 2, 3, 6..9, 11..14. Opcode 10 loads zero only.
  assign flag_all_en  = (opcode == 4'd2) || (opcode == 4'd3) ||
                        ((opcode >= 4'd6) && (opcode <= 4'd9)) ||
                        ((opcode >= 4'd11) && (opcode <= 4'd14));
  assign flag_zero_en = (opcode == OP_TSTZ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = (opcode == OP_HALT) ? ST_HALT : ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      flags_q     <= '0;
      wb_data_q   <= '0;
      alu_flags_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && instr_valid) ir_q <= instr_data;
      if (in_exec) begin
        // MOV bypasses the ALU and writes operand B directly.
        wb_data_q   <= (opcode == OP_MOV) ? operand_b : alu_result;
        alu_flags_q <= alu_flags[7:4];
      end
      if (state_q == ST_WB) begin
        if (write_en) regs_q[dst] <= wb_data_q;
        if (flag_all_en)       flags_q    <= alu_flags_q;
        else if (flag_zero_en) flags_q[3] <= alu_flags_q[3];
      end
    end
  end

  // Reset forces IDLE asynchronously, which zeroes these outputs with it.
  assign instr_ready = (state_q == ST_IDLE) && rst_n;
  assign alu_mode    = (in_exec && (opcode != OP_MOV)) ? opcode : 4'd0;
  assign alu_a       = in_exec ? regs_q[dst] : '0;
  assign alu_b       = in_exec ? operand_b : '0;
  assign flags       = {flags_q, 4'b0000};
  assign retire      = (state_q == ST_WB);
  assign halted      = (state_q == ST_HALT);
  assign dbg_data    = regs_q[dbg_sel];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer. The bench plays the role of the external ALU,
// supplying random results and flags, and keeps an architectural model
// (four registers plus a flags byte) updated from the instruction rules.
// Directed cases cover reset, MOV, ADD, CMP, HALT and reset mid-instruction;
// a random phase runs a stream of opcodes 0..14.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic [15:0]   instr_data;
  logic          instr_ready;
  logic [3:0]    alu_mode;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;
  logic [7:0]    alu_flags;
  logic [7:0]    flags;
  logic          retire;
  logic          halted;
  logic [1:0]    dbg_sel;
  logic [W-1:0]  dbg_data;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model.
  logic [W-1:0] m_regs [4];
  logic [7:0]   m_flags;

  alu_sequencer #(.WORD_SIZE(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .alu_mode    (alu_mode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .flags       (flags),
    .retire      (retire),
    .halted      (halted),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [W-1:0] model_opb(input logic [15:0] w);
`ifdef ALU_SEQUENCER_IMM_EN
    if (w[9]) return W'(w[7:0]);
`endif
    return m_regs[w[1:0]];
  endfunction

  function automatic bit op_writes(input int op);
    return (op == 1) || (op >= 4 && op <= 14);
  endfunction

  function automatic bit op_all_flags(input int op);
    return (op == 2) || (op == 3) || (op >= 6 && op <= 9) || (op >= 11 && op <= 14);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flags = 8'h00;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Entered and left on a falling edge. Runs one instruction through
  // IDLE, EXEC and WB, checking each cycle, then updates the model.
  task automatic do_instr(input logic [15:0] w, input logic [W-1:0] res, input logic [7:0] fl);
    int           op;
    int           d;
    logic [W-1:0] b_exp;
    op    = int'(w[15:12]);
    d     = int'(w[11:10]);
    b_exp = model_opb(w);
    // IDLE: previous instruction's effects are now visible.
    @(negedge clk);
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("idle_retire", 32'(retire), 32'd0);
    check("idle_mode", 32'(alu_mode), 32'd0);
    check("idle_flags", 32'(flags), 32'(m_flags));
    check("idle_dbg", 32'(dbg_data), 32'(m_regs[dbg_sel]));
    instr_valid = 1'b1;
    instr_data  = w;
    alu_result  = W'($urandom);
    alu_flags   = 8'($urandom);
    // EXEC
    @(negedge clk);
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("exec_retire", 32'(retire), 32'd0);
    check("exec_mode", 32'(alu_mode), (op == 1) ? 32'd0 : 32'(op));
    check("exec_a", 32'(alu_a), 32'(m_regs[d]));
    check("exec_b", 32'(alu_b), 32'(b_exp));
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 16'($urandom);
    alu_result  = res;
    alu_flags   = fl;
    dbg_sel     = 2'(d);
    @(negedge clk);
    if (op == 15) begin
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_retire", 32'(retire), 32'd0);
      check("halt_ready", 32'(instr_ready), 32'd0);
      return;
    end
    // WB: retire pulses, register still shows the old value.
    check("wb_retire", 32'(retire), 32'd1);
    check("wb_ready", 32'(instr_ready), 32'd0);
    check("wb_mode", 32'(alu_mode), 32'd0);
    check("wb_dbg_old", 32'(dbg_data), 32'(m_regs[d]));
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 16'($urandom);
    alu_result  = W'($urandom);
    alu_flags   = 8'($urandom);
    if (op_writes(op)) m_regs[d] = (op == 1) ? b_exp : res;
    if (op_all_flags(op))  m_flags = {fl[7:4], 4'h0};
    else if (op == 10)     m_flags = {fl[7], m_flags[6:0]};
    instr_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_alu", {alu_mode, 12'h0, alu_a, alu_b}, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    model_reset();
    check_all_regs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 32'(instr_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] w;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
    alu_result  = '0;
    alu_flags   = 8'h00;
    dbg_sel     = 2'd0;
    model_reset();

    apply_reset();

`ifdef ALU_SEQUENCER_IMM_EN
    // MOV R1,#0x05
    do_instr(16'h1605, 8'hAA, 8'hF0);
    check_all_regs("mov_imm");
    check("mov_imm_flags", 32'(flags), 32'h00);
`endif

    // Load R0=0x7F, R1=0x01 through opcode 4 (writes, no flag change).
    do_instr(16'h4000, 8'h7F, 8'hF0);
    do_instr(16'h4400, 8'h01, 8'hF0);
    // ADD R0,R1 with ALU returning 0x80 / 0x50.
    do_instr(16'h6001, 8'h80, 8'h50);
    @(negedge clk);
    check("add_flags", 32'(flags), 32'h50);
    check_all_regs("add");

    // CMP R2,R3 with ALU flags 0x80: flags load, R2 untouched.
    do_instr(16'h4800, 8'h33, 8'h00);
    do_instr(16'h2803, 8'h11, 8'h80);
    @(negedge clk);
    check("cmp_flags", 32'(flags), 32'h80);
    check("cmp_retire_once", 32'(retire), 32'd0);
    check_all_regs("cmp");

    // Random stream, back to back.
    for (int i = 0; i < 80; i++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      do_instr(w, W'($urandom), 8'($urandom));
    end
    @(negedge clk);
    check("rand_flags", 32'(flags), 32'(m_flags));
    check_all_regs("rand");

    // Reset during EXEC of ADD R0,R1.
    apply_reset();
    do_instr(16'h4000, 8'h7F, 8'h00);
    do_instr(16'h4400, 8'h01, 8'h00);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = 16'h6001;
    alu_result  = 8'h80;
    alu_flags   = 8'h50;
    @(negedge clk);
    check("mid_exec_mode", 32'(alu_mode), 32'd6);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_retire", 32'(retire), 32'd0);
    @(negedge clk);
    check("mid_rst_retire2", 32'(retire), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(instr_ready), 32'd1);
    check("mid_rel_flags", 32'(flags), 32'd0);
    check_all_regs("mid");

    // HALT, then valid held high: no progress until reset.
    do_instr(16'h4C00, 8'h5A, 8'h00);
    do_instr(16'hF000, 8'h00, 8'h00);
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr_data = 16'h4000 | 16'($urandom_range(0, 255));
      @(negedge clk);
      check("halt_hold_halted", 32'(halted), 32'd1);
      check("halt_hold_ready", 32'(instr_ready), 32'd0);
      check("halt_hold_retire", 32'(retire), 32'd0);
    end
    check_all_regs("halt_hold");
    instr_valid = 1'b0;
    apply_reset();
    check("post_halt_halted", 32'(halted), 32'd0);
    do_instr(16'h0000, 8'hFF, 8'hF0);
    @(negedge clk);
    check("nop_flags", 32'(flags), 32'd0);
    check_all_regs("post_halt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 8, as the datapath width of registers, ALU operands and result.
REQ-002 The block SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 instr_valid  in  1  instruction word offered; instr_data  in  16  instruction word; instr_ready  out  1  sequencer accepts word.
REQ-005 alu_mode  out  4  ALU operation select; alu_a  out  WORD_SIZE  operand A; alu_b  out  WORD_SIZE  operand B.
REQ-006 alu_result  in  WORD_SIZE  ALU output; alu_flags  in  8  ALU flags ([7] zero, [6] sign, [5] carry, [4] overflow).
REQ-007 flags  out  8  architectural flags register; retire  out  1  one-cycle pulse per completed instruction; halted  out  1  HALT executed.
REQ-008 dbg_sel  in  2  debug register select; dbg_data  out  WORD_SIZE  combinational read of R[dbg_sel].

Function
REQ-009 Instruction format SHALL be: [15:12] opcode, [11:10] dst, [9] imm, [8] reserved (ignored), [7:0] imm8 when imm=1 else [1:0] src.
REQ-010 The block SHALL hold four WORD_SIZE registers R0-R3; imm8 SHALL be zero-extended or truncated to WORD_SIZE.
REQ-011 FSM states SHALL be IDLE, EXEC, WB, HALT; instr_ready SHALL be 1 only in IDLE with rst_n high.
REQ-012 IDLE: on instr_valid && instr_ready the word SHALL be latched into an instruction register and the FSM SHALL go to EXEC; otherwise stay IDLE.
REQ-013 EXEC (one cycle): alu_mode SHALL equal opcode, alu_a SHALL equal R[dst], alu_b SHALL equal imm8 or R[src]; alu_result and alu_flags SHALL be sampled at the end of EXEC; next state WB.
REQ-014 Outside EXEC alu_mode, alu_a, alu_b SHALL be 0.
REQ-015 WB (one cycle): retire SHALL be 1, writeback and flag update SHALL occur at the closing edge, next state IDLE.
REQ-016 Latency: word accepted at edge N -> EXEC cycle N+1, WB/retire cycle N+2, instr_ready high again cycle N+3; peak throughput one instruction per 3 cycles.
REQ-017 Writeback to R[dst] SHALL occur for opcodes 1 and 4-14; opcodes 0, 2, 3, 15 SHALL NOT write any register.
REQ-018 Opcode 1 (MOV) SHALL write operand B to R[dst] directly, drive alu_mode=0 in EXEC, and leave flags unchanged.
REQ-019 flags[7:4] SHALL load alu_flags[7:4] for opcodes 2, 3, 6-9, 11-14; opcode 10 SHALL load only flags[7]; opcodes 0, 1, 4, 5 SHALL leave flags unchanged; flags[3:0] SHALL always be 0.
REQ-020 Opcode 0 (NOP) SHALL retire with no state change besides the FSM.
REQ-021 Opcode 15 (HALT) SHALL go EXEC -> HALT (no WB, no retire), assert halted, hold instr_ready=0, and remain until reset.
REQ-022 dst=src SHALL read the pre-writeback value; dbg_data in the WB cycle SHALL show the old value, the new value from the next cycle.
REQ-023 instr_data and instr_valid changes outside IDLE SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, R0-R3=0, flags=0, instruction register=0, alu_mode/alu_a/alu_b=0, retire=0, halted=0, instr_ready=0.
REQ-025 Reset asserted in EXEC or WB SHALL discard the in-flight instruction with no writeback, flag change or retire; instr_ready SHALL rise in the first cycle with rst_n high.

Configuration
REQ-026 Macro ALU_SEQUENCER_IMM_EN defined: bit [9] selects imm8 as operand B per REQ-009.
REQ-027 Macro undefined: bit [9] SHALL be ignored and operand B SHALL always be R[src]; no immediate logic synthesized.

Verification
REQ-028 After reset, MOV R1,#0x05 (0x1605) -> retire at cycle N+2, dbg_sel=1 reads 0x05 from N+3, flags=0x00 (IMM_EN build).
REQ-029 R0=0x7F, R1=0x01, ADD R0,R1 (0x6001), ALU returns 0x80/flags 0x50 -> R0=0x80, flags=0x50.
REQ-030 CMP R2,R3 (0x2803) with ALU flags 0x80 -> flags=0x80, R2 unchanged, retire pulses once.
REQ-031 HALT (0xF000) then instr_valid held high -> halted=1, instr_ready=0, no further retire; rst_n pulse -> halted=0, R0-R3=0.
REQ-032 rst_n low during EXEC of ADD R0,R1 -> no retire, R0=0, flags=0, instr_ready=1 first cycle after release.
REQ-033 Back-to-back valid words -> instr_ready pattern 1,0,0,1 per instruction; exactly one retire per accepted word.
